// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: per-register countdown to writeback, issue stall on RAW/WAW.
// Optional SCOREBOARD_FWD_EN: RAW ignores counts at or below FWD_SLACK (forwarded results).

module reg_scoreboard_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] lat,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (reset || clr)    cnt <= '0;
    else if (load)       cnt <= lat;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end
endmodule

module reg_scoreboard #(
  parameter int ALU_LAT   = 2,
  parameter int LOAD_LAT  = 4,
  parameter int CNT_W     = 3,
  parameter int FWD_SLACK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rs,
  input  logic [4:0]  iss_rt,
  input  logic        iss_use_rt,
  input  logic        iss_wr,
  input  logic [4:0]  iss_rd,
  input  logic        iss_load,
  output logic        stall,
  output logic        iss_fire,
  output logic [31:0] busy_vec
);
  localparam logic [CNT_W-1:0] ALU_L  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_L = CNT_W'(LOAD_LAT);
`ifdef SCOREBOARD_FWD_EN
  localparam logic [CNT_W-1:0] RAW_THR = CNT_W'(FWD_SLACK);
`else
  // Without forwarding any nonzero count blocks a reader.
  localparam logic [CNT_W-1:0] RAW_THR = CNT_W'(0 * FWD_SLACK);
`endif

  logic [CNT_W-1:0] cnt [32];
  logic [CNT_W-1:0] lat;
  logic             raw, waw;

  assign cnt[0] = '0;
  assign lat    = iss_load ? LOAD_L : ALU_L;

  always_comb begin
    raw = (cnt[iss_rs] > RAW_THR) || (iss_use_rt && (cnt[iss_rt] > RAW_THR));
    waw = iss_wr && (iss_rd != 5'd0) && (cnt[iss_rd] > lat);
  end

  // A flush/reset cycle discards everything, so nothing is worth holding back.
  assign stall    = iss_valid && !reset && !flush && (raw || waw);
  assign iss_fire = iss_valid && !stall;

  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < 32; r++) begin : g_reg
    reg_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .load  (iss_fire && iss_wr && (iss_rd == 5'(r))),
      .lat   (lat),
      .cnt   (cnt[r])
    );
    assign busy_vec[r] = (cnt[r] != '0);
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: reset, RAW, r0, WAW, flush, reset-as-flush, rt gating.
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        reset, flush, iss_valid, iss_use_rt, iss_wr, iss_load;
  logic [4:0]  iss_rs, iss_rt, iss_rd;
  logic        stall, iss_fire;
  logic [31:0] busy_vec;
  int          n_chk = 0;
  int          n_pass = 0;

`ifdef SCOREBOARD_FWD_EN
  localparam int LU_LAST_STALL = 3;
`else
  localparam int LU_LAST_STALL = 4;
`endif

  reg_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .iss_valid(iss_valid),
    .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_use_rt(iss_use_rt), .iss_wr(iss_wr),
    .iss_rd(iss_rd), .iss_load(iss_load), .stall(stall), .iss_fire(iss_fire),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_use_rt = 0;
    iss_wr = 0; iss_rd = 0; iss_load = 0;
  endtask

  task automatic iss(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                     input logic wr, input logic [4:0] rd, input logic ld);
    iss_valid = 1; iss_rs = rs; iss_rt = rt; iss_use_rt = use_rt;
    iss_wr = wr; iss_rd = rd; iss_load = ld;
  endtask

  initial begin
    reset = 1; flush = 0; idle();
    // Test 1: reset state, then a single ALU write to r5
    cyc(); cyc();
    #1;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fire_idle", {31'd0, iss_fire}, 32'd0);
    iss(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("rst_fire_eq_valid", {31'd0, iss_fire}, 32'd1);
    reset = 0;
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    #1;
    chk("t1_fire", {31'd0, iss_fire}, 32'd1);
    cyc(); idle(); #1;
    chk("t1_busy_t1", busy_vec, 32'h20);
    cyc();
    chk("t1_busy_t2", busy_vec, 32'h20);
    cyc();
    chk("t1_busy_t3", busy_vec, 32'h0);

    // Test 2: load-use RAW on r3
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1);
    #1;
    chk("t2_ld_fire", {31'd0, iss_fire}, 32'd1);
    cyc();
    iss(5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk($sformatf("t2_stall_t%0d", k), {31'd0, stall}, {31'd0, k <= LU_LAST_STALL});
      chk($sformatf("t2_fire_t%0d", k), {31'd0, iss_fire}, {31'd0, k > LU_LAST_STALL});
      cyc();
    end
    idle(); #1;
    chk("t2_clear", busy_vec, 32'h0);

    // Test 3: register 0 is never pending
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1);
    #1;
    chk("t3_fire", {31'd0, iss_fire}, 32'd1);
    cyc();
    iss(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    chk("t3_stall", {31'd0, stall}, 32'd0);
    chk("t3_busy", busy_vec, 32'h0);
    cyc(); idle();

    // Test 4: WAW, load r7 then ALU r7
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
    #1;
    chk("t4_ld_fire", {31'd0, iss_fire}, 32'd1);
    cyc();
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    #1;
    chk("t4_stall_t1", {31'd0, stall}, 32'd1);
    cyc();
    chk("t4_stall_t2", {31'd0, stall}, 32'd1);
    cyc();
    chk("t4_fire_t3", {31'd0, iss_fire}, 32'd1);
    cyc(); idle(); #1;
    chk("t4_busy_t4", busy_vec, 32'h80);
    cyc();
    chk("t4_busy_t5", busy_vec, 32'h80);
    cyc();
    chk("t4_busy_t6", busy_vec, 32'h0);

    // Test 5: flush with a concurrent write to r4 and a pending source
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1);
    cyc();
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1);
    cyc();
    chk("t5_busy_pre", busy_vec, 32'h204);
    flush = 1;
    iss(5'd2, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    #1;
    chk("t5_flush_stall", {31'd0, stall}, 32'd0);
    cyc(); flush = 0; idle(); #1;
    chk("t5_busy_post", busy_vec, 32'h0);

    // Reset mid-operation overrides flush and clears pending state
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b1);
    cyc();
    chk("rm_busy_pre", busy_vec, 32'h400);
    reset = 1; flush = 1;
    iss(5'd10, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0);
    #1;
    chk("rm_stall", {31'd0, stall}, 32'd0);
    cyc(); reset = 0; flush = 0; idle(); #1;
    chk("rm_busy_post", busy_vec, 32'h0);

    // Test 6: rt only matters when used; WAW boundary at cnt == L
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1);
    cyc();
    iss(5'd0, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("t6_rt_unused", {31'd0, stall}, 32'd0);
    iss_use_rt = 1; #1;
    chk("t6_rt_used", {31'd0, stall}, 32'd1);
    chk("t6_rt_fire", {31'd0, iss_fire}, 32'd0);
    iss_valid = 0; #1;
    chk("t6_novalid", {31'd0, stall}, 32'd0);
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
    #1;
    chk("t6_waw_alu", {31'd0, stall}, 32'd1);
    iss(5'd0, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1);
    #1;
    chk("t6_waw_eq_lat", {31'd0, stall}, 32'd0);
    cyc(); idle(); #1;
    chk("t6_busy", busy_vec, 32'h40);
    cyc(); cyc(); cyc(); cyc();
    chk("t6_busy_end", busy_vec, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-write scoreboard for the pipelined datapath's issue stage: the producer side of register hazard detection. It records each in-flight destination register with a countdown to writeback and stalls issue while an instruction's source or destination register is still pending. Per-operand equality comparisons happen downstream at the forwarding muxes; this block owns the write-pending state those comparisons depend on. Register 0 is hard-wired and never pending.

## Interface
- ALU_LAT, 2: cycles from issue until an ALU result is written back (1..2^CNT_W-1).
- LOAD_LAT, 4: cycles from issue until a load result is written back (1..2^CNT_W-1).
- CNT_W, 3: width of each per-register countdown counter.
- FWD_SLACK, 1: counter value at or below which a result is forwardable (used only with forwarding, see Configuration).
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush; discards all pending entries.
- iss_valid  input  1  an instruction is presented for issue.
- iss_rs  input  5  source register A.
- iss_rt  input  5  source register B.
- iss_use_rt  input  1  the instruction reads iss_rt.
- iss_wr  input  1  the instruction writes iss_rd.
- iss_rd  input  5  destination register.
- iss_load  input  1  1 selects LOAD_LAT, 0 selects ALU_LAT.
- stall  output  1  issue blocked this cycle (combinational).
- iss_fire  output  1  iss_valid & ~stall; the instruction is accepted this cycle.
- busy_vec  output  32  bit r = 1 when cnt[r] != 0; bit 0 always 0.

## Operation
- State: cnt[1..31], CNT_W bits each. cnt[0] is a constant 0.
- Latency select: L = iss_load ? LOAD_LAT : ALU_LAT.
- RAW hazard: hz(r) = (cnt[r] != 0), or (cnt[r] > FWD_SLACK) with forwarding. Stall if hz(iss_rs), or if iss_use_rt & hz(iss_rt).
- WAW hazard: stall if iss_wr & (iss_rd != 0) & (cnt[iss_rd] > L). This prevents an older, slower write from landing after a newer one.
- stall = iss_valid & (RAW | WAW). It is 0 whenever iss_valid = 0 and during flush/reset cycles.
- Each edge, with priority reset > flush > normal:
  - reset or flush: every cnt is set to 0.
  - iss_fire & iss_wr & iss_rd != 0: cnt[iss_rd] is loaded with L.
  - All other nonzero counters decrement by 1. Counters at 0 hold; they never wrap.
- Issue to a register whose counter is nonzero but <= L: the counter is overwritten with L (no decrement that cycle).
- iss_rd = 0 or iss_wr = 0: no counter is loaded.

## Timing
- Reset values: all counters 0, busy_vec = 0, stall = 0, iss_fire = iss_valid.
- An instruction fires in cycle t with latency L: cnt[rd] = L in cycle t+1 and reaches 0 in cycle t+L+1.
- Without forwarding, a dependent instruction can fire no earlier than t+L+1.
- With forwarding, a dependent instruction can fire at t+L+1-FWD_SLACK (minimum t+1).
- stall and iss_fire are combinational from the current state and issue inputs, with zero latency. busy_vec is registered-state decode.
- Flush in cycle t: busy_vec = 0 in cycle t+1. An iss_fire in the same cycle is overridden and its register is not marked.
- Reset asserted mid-operation behaves identically to flush and overrides it.

## Configuration
- SCOREBOARD_FWD_EN defined: a RAW hazard is counted only when cnt[r] > FWD_SLACK, because results with at most FWD_SLACK cycles remaining are supplied by the forwarding network.
- SCOREBOARD_FWD_EN undefined: a RAW hazard is counted when cnt[r] != 0, and FWD_SLACK is unused.
- The WAW rule is the same in both builds.

## Test plan
- Test 1, reset: assert reset 2 cycles with iss_valid = 0 → busy_vec = 0 and stall = 0. Then issue wr rd=5 ALU (no FWD) → busy_vec[5] = 1 for cycles t+1..t+2 and 0 at t+3.
- Test 2, load-use RAW (no FWD): load rd=3 at t, then rs=3 held valid → stall = 1 in cycles t+1..t+4, iss_fire = 1 at t+5. With SCOREBOARD_FWD_EN (FWD_SLACK = 1) → iss_fire at t+4.
- Test 3, register 0: issue wr rd=0 load, then rs=0 → busy_vec stays 0 and no stall occurs.
- Test 4, WAW: load rd=7 at t, then ALU rd=7 at t+1 (cnt = 4 > 2) → stall at t+1 and t+2, fire at t+3, cnt[7] = 2 at t+4.
- Test 5, flush: loads to rd=2 and rd=9, flush at t+1 with a valid wr rd=4 → busy_vec = 0 at t+2 and rd=4 is not marked.
- Test 6, unused rt: pending rt=6 with iss_use_rt = 0 → stall = 0. The same stimulus with iss_use_rt = 1 → stall = 1.
